// File: rtl/ysyx_22041412_divider.sv
// Multi-cycle RV64M divide/remainder unit: radix-2 restoring division, one quotient bit per
// cycle, with divide-by-zero and signed-overflow results resolved at accept.
module ysyx_22041412_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_word,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] scr1,
  input  logic [XLEN-1:0] scr2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] x);
    return {{HALF{x[HALF-1]}}, x};
  endfunction

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
    return {XLEN{1'b0}} - x;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [XLEN-1:0] rem_r, quo_r, div_r, result_r;
  logic            word_r, rem_op_r, qneg_r, rneg_r;

  logic            fire_s, sgn_s, s1_s, s2_s, div0_s, ovf_s, special_s, last_s, ge_s;
  logic [XLEN-1:0] a_ext_s, b_ext_s, min_s, mag1_s, mag2_s, spec_res_s;
  logic [XLEN:0]   part_s, diff_s;
  logic [XLEN-1:0] rem_nxt_s, quo_nxt_s, q_raw_s, sel_s, final_s;
  logic            unused_s;

  assign unused_s  = func3[2];
  assign in_ready  = (state_r == IDLE) & ~flush;
  assign fire_s    = in_valid & in_ready;
  assign busy      = (state_r != IDLE);
  assign out_valid = (state_r == DONE);
  assign result    = result_r;

  // Operands extended to full width so one datapath serves both word and doubleword ops.
  assign sgn_s   = ~func3[0];
  assign a_ext_s = is_word ? (sgn_s ? sext_half(scr1[HALF-1:0]) : {{HALF{1'b0}}, scr1[HALF-1:0]}) : scr1;
  assign b_ext_s = is_word ? (sgn_s ? sext_half(scr2[HALF-1:0]) : {{HALF{1'b0}}, scr2[HALF-1:0]}) : scr2;
  assign min_s   = is_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign s1_s    = sgn_s & a_ext_s[XLEN-1];
  assign s2_s    = sgn_s & b_ext_s[XLEN-1];
  assign mag1_s  = s1_s ? neg(a_ext_s) : a_ext_s;
  assign mag2_s  = s2_s ? neg(b_ext_s) : b_ext_s;
  assign div0_s  = (b_ext_s == {XLEN{1'b0}});
  assign ovf_s   = sgn_s & (a_ext_s == min_s) & (b_ext_s == {XLEN{1'b1}});
  assign special_s = div0_s | ovf_s;

  // Special-case result chosen directly from the RISC-V defined values.
  always_comb begin
    spec_res_s = {XLEN{1'b0}};
    if (div0_s) begin
      if (func3[1]) begin
        spec_res_s = is_word ? sext_half(scr1[HALF-1:0]) : scr1;
      end else begin
        spec_res_s = {XLEN{1'b1}};
      end
    end else begin
      spec_res_s = func3[1] ? {XLEN{1'b0}} : a_ext_s;
    end
  end

  // One restoring step; partial remainder can exceed XLEN bits only transiently.
  assign part_s    = {rem_r, quo_r[XLEN-1]};
  assign diff_s    = part_s - {1'b0, div_r};
  assign ge_s      = part_s[XLEN] | ~diff_s[XLEN];
  assign rem_nxt_s = ge_s ? diff_s[XLEN-1:0] : part_s[XLEN-1:0];
  assign quo_nxt_s = {quo_r[XLEN-2:0], ge_s};
  assign last_s    = (cnt_r == (word_r ? CW'(HALF - 1) : CW'(XLEN - 1)));

  // Sign fixup and word sign-extension folded into the final step.
  assign q_raw_s = word_r ? {{HALF{1'b0}}, quo_nxt_s[HALF-1:0]} : quo_nxt_s;
  assign sel_s   = rem_op_r ? (rneg_r ? neg(rem_nxt_s) : rem_nxt_s)
                            : (qneg_r ? neg(q_raw_s) : q_raw_s);
  assign final_s = word_r ? sext_half(sel_s[HALF-1:0]) : sel_s;

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = fire_s ? (special_s ? DONE : CALC) : IDLE;
        CALC:    state_nxt_s = last_s ? DONE : CALC;
        DONE:    state_nxt_s = out_ready ? IDLE : DONE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers: capture at accept, iterate in CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CW{1'b0}};
      rem_r    <= {XLEN{1'b0}};
      quo_r    <= {XLEN{1'b0}};
      div_r    <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
      word_r   <= 1'b0;
      rem_op_r <= 1'b0;
      qneg_r   <= 1'b0;
      rneg_r   <= 1'b0;
    end else if (flush) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (fire_s) begin
            word_r   <= is_word;
            rem_op_r <= func3[1];
            qneg_r   <= s1_s ^ s2_s;
            rneg_r   <= s1_s;
            cnt_r    <= {CW{1'b0}};
            rem_r    <= {XLEN{1'b0}};
            div_r    <= mag2_s;
            // Word dividends sit in the upper half so 32 shifts consume exactly their bits.
            quo_r    <= is_word ? {mag1_s[HALF-1:0], {HALF{1'b0}}} : mag1_s;
            if (special_s) begin
              result_r <= spec_res_s;
            end
          end
        end
        CALC: begin
          rem_r <= rem_nxt_s;
          quo_r <= quo_nxt_s;
          if (last_s) begin
            cnt_r    <= {CW{1'b0}};
            result_r <= final_s;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_divider.sv
// Self-checking bench for ysyx_22041412_divider: directed vector table, multi-cycle corner
// sequences, and randomized ops compared against a plain-arithmetic reference model.
module tb_ysyx_22041412_divider;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, is_word, out_valid, out_ready, busy;
  logic [2:0]  func3;
  logic [63:0] scr1, scr2, result;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  ysyx_22041412_divider dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .is_word(is_word), .func3(func3), .scr1(scr1), .scr2(scr2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the RISC-V M-extension rules.
  task automatic ref_div(input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] res, output logic sp);
    logic [31:0] a32, b32, q32, r32, t32;
    logic [63:0] q, r;
    sp = 1'b0;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32; sp = 1'b1;
      end else if (!f3[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0; sp = 1'b1;
      end else if (f3[0]) begin
        q32 = a32 / b32; r32 = a32 % b32;
      end else begin
        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
      end
      t32 = f3[1] ? r32 : q32;
      res = {{32{t32[31]}}, t32};
    end else begin
      if (b == 64'd0) begin
        q = '1; r = a; sp = 1'b1;
      end else if (!f3[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 64'd0; sp = 1'b1;
      end else if (f3[0]) begin
        q = a / b; r = a % b;
      end else begin
        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
      end
      res = f3[1] ? r : q;
    end
  endtask

  // Issue one op from IDLE (called #1 after an edge); returns at first out_valid sample.
  task automatic do_op(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output int lat);
    chk("in_ready_before_op", {63'd0, in_ready}, 64'd1);
    is_word = w; func3 = f3; scr1 = a; scr2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scr1 = {$urandom, $urandom}; scr2 = {$urandom, $urandom};
    func3 = 3'($urandom); is_word = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  vec_t        vt[13];
  logic [63:0] res, exp;
  logic        sp;
  int          lat;
  int          seen;

  initial begin
    vt[0]  = '{1'b0, F_DIV,  -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65};
    vt[1]  = '{1'b0, F_REM,  -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vt[2]  = '{1'b0, F_DIVU, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vt[3]  = '{1'b0, F_REMU, 64'h1234, 64'd0, 64'h0000_0000_0000_1234, 1};
    vt[4]  = '{1'b0, F_DIV,  64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
    vt[5]  = '{1'b0, F_REM,  64'h8000_0000_0000_0000, '1, 64'd0, 1};
    vt[6]  = '{1'b1, F_DIVU, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vt[7]  = '{1'b1, F_REM,  64'd7, -64'sd2, 64'd1, 33};
    vt[8]  = '{1'b1, F_DIV,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vt[9]  = '{1'b1, F_DIV,  64'd55, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vt[10] = '{1'b1, F_REMU, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1};
    vt[11] = '{1'b0, F_DIVU, '1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vt[12] = '{1'b0, F_REMU, '1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 65};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    is_word = 1'b0; func3 = 3'd0; scr1 = 64'd0; scr2 = 64'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

    foreach (vt[i]) begin
      do_op(vt[i].w, vt[i].f3, vt[i].a, vt[i].b, res, lat);
      chk($sformatf("vec%0d_result", i), res, vt[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
      tick();
    end

    // Backpressure: result held while consumer stalls.
    out_ready = 1'b0;
    do_op(1'b0, F_DIV, -64'sd20, 64'd3, res, lat);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_result", result, 64'hFFFF_FFFF_FFFF_FFFA);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);

    // Flush in CALC cycle 20.
    is_word = 1'b0; func3 = F_DIVU; scr1 = 64'd1000; scr2 = 64'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (19) tick();
    chk("calc_busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    #1 chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    seen = 0;
    for (int k = 0; k < 70; k++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("flush_no_output", 64'(seen), 64'd0);

    // Request coincident with flush is ignored.
    in_valid = 1'b1; flush = 1'b1;
    #1 chk("flush_req_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_req_busy", {63'd0, busy}, 64'd0);

    // Asynchronous reset mid-CALC.
    is_word = 1'b0; func3 = F_DIV; scr1 = 64'd999; scr2 = 64'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", result, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 70; k++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("rst_no_output", 64'(seen), 64'd0);
    do_op(1'b0, F_DIVU, 64'd100, 64'd7, res, lat);
    chk("post_rst_divu", res, 64'd14);
    tick();

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic        w;
      logic [2:0]  f3;
      logic [63:0] a, b;
      int          mode;
      w    = 1'($urandom);
      f3   = 3'($urandom_range(4, 7));
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      mode = $urandom_range(0, 5);
      case (mode)
        0: b = w ? {b[63:32], 32'd0} : 64'd0;
        1: begin
          a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = '1;
        end
        2: b = 64'($urandom_range(1, 300));
        3: a = 64'($urandom_range(0, 5000));
        default: b = b >> $urandom_range(0, 60);
      endcase
      if ($urandom_range(0, 1) == 1) b = -b;
      ref_div(w, f3, a, b, exp, sp);
      do_op(w, f3, a, b, res, lat);
      chk($sformatf("rnd%0d_w%0d_f%0d_result", n, w, f3), res, exp);
      chk($sformatf("rnd%0d_latency", n), 64'(lat), sp ? 64'd1 : (w ? 64'd33 : 64'd65));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
